// File: rtl/multicycle_control_pkg.sv
// Shared definitions for the RV32I multi-cycle sequencer: state encoding,
// opcode constants, ALU operation codes and datapath mux selects.
package multicycle_control_pkg;

  localparam int ALU_CODE_W = 5;
  typedef logic [ALU_CODE_W-1:0] alu_op_t;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC     = 4'd2,
    S_ALU_WB   = 4'd3,
    S_MEM_ADDR = 4'd4,
    S_MEM_RD   = 4'd5,
    S_LOAD_WB  = 4'd6,
    S_MEM_WR   = 4'd7,
    S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9,
    S_TRAP     = 4'd10
  } state_e;

  // Which family of ALU codes the decoder should choose from.
  typedef enum logic [1:0] {
    CLS_ADD,
    CLS_EXEC,
    CLS_LOAD,
    CLS_BRANCH
  } op_class_e;

  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;

  localparam alu_op_t add_ALU  = 5'd0;
  localparam alu_op_t sub_ALU  = 5'd1;
  localparam alu_op_t xor_ALU  = 5'd2;
  localparam alu_op_t or_ALU   = 5'd3;
  localparam alu_op_t and_ALU  = 5'd4;
  localparam alu_op_t sll_ALU  = 5'd5;
  localparam alu_op_t slli_ALU = 5'd6;
  localparam alu_op_t srl_ALU  = 5'd7;
  localparam alu_op_t sra_ALU  = 5'd8;
  localparam alu_op_t srli_ALU = 5'd9;
  localparam alu_op_t srai_ALU = 5'd10;
  localparam alu_op_t slt_ALU  = 5'd11;
  localparam alu_op_t sltu_ALU = 5'd12;
  localparam alu_op_t lb_ALU   = 5'd13;
  localparam alu_op_t lh_ALU   = 5'd14;
  localparam alu_op_t lw_ALU   = 5'd15;
  localparam alu_op_t lbu_ALU  = 5'd16;
  localparam alu_op_t lhu_ALU  = 5'd17;
  localparam alu_op_t beq_ALU  = 5'd18;
  localparam alu_op_t bne_ALU  = 5'd19;
  localparam alu_op_t bge_ALU  = 5'd20;
  localparam alu_op_t bgeu_ALU = 5'd21;

  localparam logic [1:0] A_RS1   = 2'd0;
  localparam logic [1:0] A_PC    = 2'd1;
  localparam logic [1:0] A_OLDPC = 2'd2;
  localparam logic [1:0] A_ZERO  = 2'd3;
  localparam logic [1:0] B_RS2   = 2'd0;
  localparam logic [1:0] B_IMM   = 2'd1;
  localparam logic [1:0] B_FOUR  = 2'd2;
  localparam logic [1:0] B_MEM   = 2'd3;

  function automatic state_e decode_next(input logic [6:0] opcode);
    case (opcode)
      OP, OP_IMM, LUI, AUIPC: return S_EXEC;
      LOAD, STORE:            return S_MEM_ADDR;
      BRANCH:                 return S_BRANCH;
      JAL, JALR:              return S_JUMP;
      default:                return S_TRAP;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_control_alu_op_decode.sv
// Maps the current state class and IR fields onto the shared ALU operation code.
module multicycle_control_alu_op_decode
  import multicycle_control_pkg::*;
(
  input  op_class_e  op_class,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic [6:0] opcode,
  output alu_op_t    alu_op
);

  logic is_op;
  assign is_op = (opcode == OP);

  always_comb begin
    alu_op = add_ALU;
    case (op_class)
      CLS_EXEC: begin
        // LUI/AUIPC carry immediate bits in funct3, so they stay on add.
        if (opcode == OP || opcode == OP_IMM) begin
          case (funct3)
            3'b000: alu_op = (is_op && funct7b5) ? sub_ALU : add_ALU;
            3'b001: alu_op = is_op ? sll_ALU : slli_ALU;
            3'b010: alu_op = slt_ALU;
            3'b011: alu_op = sltu_ALU;
            3'b100: alu_op = xor_ALU;
            3'b101: begin
              if (is_op) alu_op = funct7b5 ? sra_ALU : srl_ALU;
              else       alu_op = funct7b5 ? srai_ALU : srli_ALU;
            end
            3'b110: alu_op = or_ALU;
            3'b111: alu_op = and_ALU;
          endcase
        end
      end
      CLS_LOAD: begin
        case (funct3)
          3'b000:  alu_op = lb_ALU;
          3'b001:  alu_op = lh_ALU;
          3'b010:  alu_op = lw_ALU;
          3'b100:  alu_op = lbu_ALU;
          3'b101:  alu_op = lhu_ALU;
          default: alu_op = add_ALU;
        endcase
      end
      CLS_BRANCH: begin
        case (funct3)
          3'b000:  alu_op = beq_ALU;
          3'b001:  alu_op = bne_ALU;
          3'b100:  alu_op = slt_ALU;
          3'b101:  alu_op = bge_ALU;
          3'b110:  alu_op = sltu_ALU;
          3'b111:  alu_op = bgeu_ALU;
          default: alu_op = add_ALU;
        endcase
      end
      default: alu_op = add_ALU;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle RV32I sequencer: steps the shared ALU, register file and memory
// port through fetch/decode and the per-class execute sequence.
//
// state    | meaning
// FETCH    | read instruction at PC, ALU forms PC+4, load IR/PC/oldPC on ready
// DECODE   | ALU forms branch/jump target into ALU-out
// EXEC     | R/I/LUI/AUIPC operation into ALU-out
// ALU_WB   | write ALU-out to rd
// MEM_ADDR | rs1+imm effective address
// MEM_RD   | load request at ALU-out, held until ready
// LOAD_WB  | extend memory data through the ALU into rd
// MEM_WR   | store request at ALU-out, held until ready
// BRANCH   | compare rs1/rs2, take target on ALU branch flag
// JUMP     | rd <= oldPC+4, PC <= target
// TRAP     | illegal instruction, parked until reset
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int ACW  = ALU_CODE_W
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] instr,
  input  logic            mem_ready,
  input  logic            branch,
  output logic            mem_req,
  output logic            mem_we,
  output logic            addr_sel,
  output logic            ir_write,
  output logic            pc_write,
  output logic            oldpc_write,
  output logic            reg_write,
  output logic            pc_sel,
  output logic [1:0]      alu_a_sel,
  output logic [1:0]      alu_b_sel,
  output logic            wb_sel,
  output logic [ACW-1:0]  ALU_control,
  output logic            illegal
);

  state_e     state;
  op_class_e  op_class;
  alu_op_t    alu_op;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       load_ok;
  logic       br_ok;
  logic       unused_instr;

  assign opcode       = instr[6:0];
  assign funct3       = instr[14:12];
  assign funct7b5     = instr[30];
  assign load_ok      = !(funct3 == 3'b011 || funct3[2:1] == 2'b11);
  assign br_ok        = (funct3[2:1] != 2'b01);
  assign unused_instr = ^{instr[XLEN-1:31], instr[29:15], instr[11:7]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_FETCH;
      illegal <= 1'b0;
    end else begin
      case (state)
        S_FETCH:    if (mem_ready) state <= S_DECODE;
        S_DECODE: begin
          state <= decode_next(opcode);
          if (decode_next(opcode) == S_TRAP) illegal <= 1'b1;
        end
        S_EXEC:     state <= S_ALU_WB;
        S_ALU_WB:   state <= S_FETCH;
        S_MEM_ADDR: state <= (opcode == LOAD) ? S_MEM_RD : S_MEM_WR;
        S_MEM_RD:   if (mem_ready) state <= S_LOAD_WB;
        S_MEM_WR:   if (mem_ready) state <= S_FETCH;
        S_LOAD_WB: begin
          if (load_ok) state <= S_FETCH;
          else begin
            state   <= S_TRAP;
            illegal <= 1'b1;
          end
        end
        S_BRANCH: begin
          if (br_ok) state <= S_FETCH;
          else begin
            state   <= S_TRAP;
            illegal <= 1'b1;
          end
        end
        S_JUMP:     state <= S_FETCH;
        S_TRAP:     state <= S_TRAP;
        default: begin
          state   <= S_TRAP;
          illegal <= 1'b1;
        end
      endcase
    end
  end

  // FETCH writes and the branch PC write follow the ready/flag inputs in the
  // same cycle so IR and PC capture on the edge that completes the access.
  always_comb begin
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    addr_sel    = 1'b0;
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    oldpc_write = 1'b0;
    reg_write   = 1'b0;
    pc_sel      = 1'b0;
    alu_a_sel   = A_RS1;
    alu_b_sel   = B_RS2;
    wb_sel      = 1'b0;
    op_class    = CLS_ADD;
    case (state)
      S_FETCH: begin
        mem_req     = 1'b1;
        alu_a_sel   = A_PC;
        alu_b_sel   = B_FOUR;
        ir_write    = mem_ready;
        pc_write    = mem_ready;
        oldpc_write = mem_ready;
      end
      S_DECODE: begin
        alu_a_sel = (opcode == JALR) ? A_RS1 : A_OLDPC;
        alu_b_sel = B_IMM;
      end
      S_EXEC: begin
        op_class = CLS_EXEC;
        case (opcode)
          OP_IMM: begin alu_a_sel = A_RS1;   alu_b_sel = B_IMM; end
          LUI:    begin alu_a_sel = A_ZERO;  alu_b_sel = B_IMM; end
          AUIPC:  begin alu_a_sel = A_OLDPC; alu_b_sel = B_IMM; end
          default: begin alu_a_sel = A_RS1;  alu_b_sel = B_RS2; end
        endcase
      end
      S_ALU_WB: begin
        reg_write = 1'b1;
        wb_sel    = 1'b1;
      end
      S_MEM_ADDR: begin
        alu_a_sel = A_RS1;
        alu_b_sel = B_IMM;
      end
      S_MEM_RD: begin
        mem_req  = 1'b1;
        addr_sel = 1'b1;
      end
      S_MEM_WR: begin
        mem_req  = 1'b1;
        addr_sel = 1'b1;
        mem_we   = 1'b1;
      end
      S_LOAD_WB: begin
        op_class  = CLS_LOAD;
        alu_b_sel = B_MEM;
        reg_write = load_ok;
      end
      S_BRANCH: begin
        op_class = CLS_BRANCH;
        pc_sel   = 1'b1;
        pc_write = branch & br_ok;
      end
      S_JUMP: begin
        reg_write = 1'b1;
        alu_a_sel = A_OLDPC;
        alu_b_sel = B_FOUR;
        pc_sel    = 1'b1;
        pc_write  = 1'b1;
      end
      default: ;
    endcase
  end

  multicycle_control_alu_op_decode u_alu_op_decode (
    .op_class (op_class),
    .funct3   (funct3),
    .funct7b5 (funct7b5),
    .opcode   (opcode),
    .alu_op   (alu_op)
  );

  assign ALU_control = ACW'(alu_op);

endmodule
